// File: rtl/sram_sp_ctrl.sv
// Single-port SRAM controller with an integrated storage array: valid/ready requests,
// byte-masked writes, a 1- or 2-cycle read pipeline and a zero-fill clear engine.
module sram_sp_ctrl #(
  parameter int ADDR_W     = 15,
  parameter int DEPTH      = 32768,
  parameter int DATA_W     = 96,
  parameter int BYTE_W     = 8,
  parameter int OUT_REG    = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                     iClk,
  input  logic                     iReset,
  input  logic                     iReqValid,
  output logic                     oReqReady,
  input  logic                     iWe,
  input  logic [ADDR_W-1:0]        iAddr,
  input  logic [DATA_W-1:0]        iWData,
  input  logic [DATA_W/BYTE_W-1:0] iWMask,
  input  logic                     iClear,
  output logic                     oRValid,
  output logic [DATA_W-1:0]        oRData,
  output logic                     oBusy
);
  localparam int                NB      = DATA_W / BYTE_W;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;
  localparam state_t RST_STATE = (INIT_CLEAR != 0) ? CLEAR : RUN;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              busy;
  logic              accept, rd_acc, in_range, wr_en, clr_en;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              vld_p0;
  logic [DATA_W-1:0] data_p0;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    oReqReady = 1'b0;
    case (state)
      CLEAR: begin
        if (cnt == LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        // A clear pulse takes priority over any request offered in the same cycle.
        oReqReady = ~iClear;
        if (iClear) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state <= RST_STATE;
      cnt   <= '0;
      busy  <= (INIT_CLEAR != 0);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt == CLEAR);
    end
  end

  assign oBusy    = busy;
  assign in_range = {1'b0, iAddr} < DEPTH_C;
  assign accept   = iReqValid & oReqReady & ~iReset;
  assign rd_acc   = accept & ~iWe;
  assign wr_en    = accept & iWe & in_range;
  assign clr_en   = (state == CLEAR) & ~iReset;

  // Storage array: reset never alters contents, only the clear engine or writes do.
  always_ff @(posedge iClk) begin
    if (clr_en) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (iWMask[b]) mem[iAddr][b*BYTE_W +: BYTE_W] <= iWData[b*BYTE_W +: BYTE_W];
      end
    end
  end

  // Stage p0: array read captured at the accepting edge; data holds between reads.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else begin
      vld_p0 <= rd_acc;
      if (rd_acc) data_p0 <= in_range ? mem[iAddr] : '0;
    end
  end

  // Stage p1: optional output register adding one cycle of latency.
  if (OUT_REG != 0) begin : g_out_reg
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    always_ff @(posedge iClk or posedge iReset) begin
      if (iReset) begin
        vld_p1  <= 1'b0;
        data_p1 <= '0;
      end else begin
        vld_p1 <= vld_p0;
        if (vld_p0) data_p1 <= data_p0;
      end
    end
    assign oRValid = vld_p1;
    assign oRData  = data_p1;
  end else begin : g_no_out_reg
    assign oRValid = vld_p0;
    assign oRData  = data_p0;
  end

endmodule

// File: tb/tb_sram_sp_ctrl.sv
// Bench for sram_sp_ctrl: two instances (DEPTH=16/1-cycle, DEPTH=12/2-cycle) share stimulus
// and are compared every cycle against a behavioural array/schedule model.
module tb_sram_sp_ctrl;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vld = 1'b0, we = 1'b0, clr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [NB-1:0] wmask = '0;
  logic          rdy0, rv0, busy0, rdy1, rv1, busy1;
  logic [DW-1:0] rd0, rd1;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  sram_sp_ctrl #(.ADDR_W(AW), .DEPTH(16), .DATA_W(DW), .BYTE_W(8), .OUT_REG(0), .INIT_CLEAR(1)) dut0 (
    .iClk(clk), .iReset(rst), .iReqValid(vld), .oReqReady(rdy0), .iWe(we), .iAddr(addr),
    .iWData(wdata), .iWMask(wmask), .iClear(clr), .oRValid(rv0), .oRData(rd0), .oBusy(busy0));

  sram_sp_ctrl #(.ADDR_W(AW), .DEPTH(12), .DATA_W(DW), .BYTE_W(8), .OUT_REG(1), .INIT_CLEAR(1)) dut1 (
    .iClk(clk), .iReset(rst), .iReqValid(vld), .oReqReady(rdy1), .iWe(we), .iAddr(addr),
    .iWData(wdata), .iWMask(wmask), .iClear(clr), .oRValid(rv1), .oRData(rd1), .oBusy(busy1));

  task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  // Behavioural model: per-instance word array, clear progress and a read-result schedule.
  int            m_dep [2] = '{16, 12};
  int            m_lat [2] = '{1, 2};
  logic [DW-1:0] m_mem [2][16];
  bit            m_clearing [2];
  int            m_pos [2];
  bit            m_ev [2];
  logic [DW-1:0] m_ed [2];
  bit            s_v [2][4];
  logic [DW-1:0] s_d [2][4];
  int            cyc = 0;
  int            slot;
  bit            acc;

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_clearing[d] = 1'b1;
        m_pos[d]      = 0;
        m_ev[d]       = 1'b0;
        m_ed[d]       = '0;
        for (int s = 0; s < 4; s++) s_v[d][s] = 1'b0;
      end else begin
        acc = vld && !m_clearing[d] && !clr;
        if (acc && !we) begin
          slot = (cyc + m_lat[d] - 1) % 4;
          s_v[d][slot] = 1'b1;
          s_d[d][slot] = (int'(addr) < m_dep[d]) ? m_mem[d][addr] : '0;
        end
        if (acc && we && int'(addr) < m_dep[d]) begin
          for (int b = 0; b < NB; b++)
            if (wmask[b]) m_mem[d][addr][8*b +: 8] = wdata[8*b +: 8];
        end
        if (m_clearing[d]) begin
          m_mem[d][m_pos[d]] = '0;
          m_pos[d]++;
          if (m_pos[d] == m_dep[d]) begin
            m_clearing[d] = 1'b0;
            m_pos[d]      = 0;
          end
        end else if (clr) begin
          m_clearing[d] = 1'b1;
          m_pos[d]      = 0;
        end
        m_ev[d] = s_v[d][cyc % 4];
        if (m_ev[d]) m_ed[d] = s_d[d][cyc % 4];
        s_v[d][cyc % 4] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    chk("m_busy0", 32'(busy0), 32'(m_clearing[0]));
    chk("m_rdy0",  32'(rdy0),  32'(!m_clearing[0] && !clr));
    chk("m_rv0",   32'(rv0),   32'(m_ev[0]));
    chk("m_rd0",   rd0,        m_ed[0]);
    chk("m_busy1", 32'(busy1), 32'(m_clearing[1]));
    chk("m_rdy1",  32'(rdy1),  32'(!m_clearing[1] && !clr));
    chk("m_rv1",   32'(rv1),   32'(m_ev[1]));
    chk("m_rd1",   rd1,        m_ed[1]);
  end

  task automatic idle();
    vld = 1'b0; we = 1'b0; clr = 1'b0; wmask = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] m);
    vld = 1'b1; we = 1'b1; addr = a; wdata = d; wmask = m;
    @(negedge clk);
    idle();
  endtask

  task automatic rd(input logic [AW-1:0] a);
    vld = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    idle();
  endtask

  task automatic count_busy(input string nm, input int exp0, input int exp1);
    int n0, n1;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy0) n0++;
      if (busy1) n1++;
      @(negedge clk);
    end
    chk({nm, "_len0"}, 32'(n0), 32'(exp0));
    chk({nm, "_len1"}, 32'(n1), 32'(exp1));
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy0", 32'(busy0), 32'd1);
    chk("rst_rdy0",  32'(rdy0),  32'd0);
    chk("rst_rv0",   32'(rv0),   32'd0);
    chk("rst_rd0",   rd0,        32'd0);
    chk("rst_busy1", 32'(busy1), 32'd1);
    rst = 1'b0;
    count_busy("init_clr", 16, 12);

    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      chk("init_rv0", 32'(rv0), 32'd1);
      chk("init_rd0", rd0, 32'd0);
    end
    @(negedge clk);

    wr(4'd3, 32'hAABBCCDD, 4'b1111);
    wr(4'd3, 32'h11223344, 4'b0101);
    rd(4'd3);
    chk("mask_rv0", 32'(rv0), 32'd1);
    chk("mask_rd0", rd0, 32'hAA22CC44);
    chk("lat2_rv1_early", 32'(rv1), 32'd0);
    @(negedge clk);
    chk("mask_rv1", 32'(rv1), 32'd1);
    chk("mask_rd1", rd1, 32'hAA22CC44);
    chk("mask_rv0_drop", 32'(rv0), 32'd0);
    chk("hold_rd0", rd0, 32'hAA22CC44);

    vld = 1'b1; we = 1'b1; addr = 4'd5; wdata = 32'h12345678; wmask = 4'hF;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      vld = 1'b1; we = 1'b0; addr = (i == 0) ? 4'd5 : 4'(i);
      @(negedge clk);
      chk("b2b_rv0", 32'(rv0), 32'd1);
      if (i == 0) chk("wtr_rd0", rd0, 32'h12345678);
    end
    idle();
    @(negedge clk);
    chk("b2b_end_rv0", 32'(rv0), 32'd0);

    clr = 1'b1; vld = 1'b1; we = 1'b1; addr = 4'd2; wdata = 32'hFFFFFFFF; wmask = 4'hF;
    @(negedge clk);
    idle();
    chk("clr_busy0", 32'(busy0), 32'd1);
    chk("clr_rdy0",  32'(rdy0),  32'd0);
    repeat (20) @(negedge clk);
    rd(4'd2);
    chk("clr_rd2", rd0, 32'd0);
    rd(4'd5);
    chk("clr_rd5", rd0, 32'd0);

    wr(4'd7, 32'hDEADBEEF, 4'hF);
    rd(4'd7);
    chk("pre_rst_rd0", rd0, 32'hDEADBEEF);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy0", 32'(busy0), 32'd1);
    chk("mid_rst_rdy0",  32'(rdy0),  32'd0);
    chk("mid_rst_rv0",   32'(rv0),   32'd0);
    chk("mid_rst_rd0",   rd0,        32'd0);
    @(negedge clk);
    rst = 1'b0;
    count_busy("rst_clr", 16, 12);

    wr(4'd3, 32'h0BADF00D, 4'hF);
    wr(4'd15, 32'hFFFFFFFF, 4'hF);
    vld = 1'b1; we = 1'b0; addr = 4'd15;
    @(negedge clk);
    addr = 4'd3;
    @(negedge clk);
    idle();
    chk("oor_rv1", 32'(rv1), 32'd1);
    chk("oor_rd1", rd1, 32'd0);
    @(negedge clk);
    chk("alias_rv1", 32'(rv1), 32'd1);
    chk("alias_rd1", rd1, 32'h0BADF00D);

    for (int i = 0; i < 3000; i++) begin
      vld   = ($urandom_range(0, 3) != 0);
      we    = 1'($urandom_range(0, 1));
      addr  = 4'($urandom_range(0, 15));
      wdata = $urandom;
      wmask = 4'($urandom);
      clr   = ($urandom_range(0, 63) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
